multi_bank_memory: RTL and testbench
====================================

MULTI_BANK_MEMORY -- requirements
Module: multi_bank_memory

Interface
REQ-001 Parameter REQUESTERS, default 4, number of read/write requester port pairs (>=1).
REQ-002 Parameter BANKS, default 2, number of independent storage banks (power of two, >=1).
REQ-003 Parameter DATA_WIDTH, default 32, bits per word.
REQ-004 Parameter ADDR_WIDTH, default 6, word address bits (> log2(BANKS)).
REQ-005 Parameter READ_LAT, default 2, cycles from read handshake to r_dvalid (>=1).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 r_addr  input  REQUESTERS x ADDR_WIDTH  read address per requester.
REQ-009 r_avalid  input  REQUESTERS  read request valid.
REQ-010 r_aready  output  REQUESTERS  read request accepted this cycle.
REQ-011 r_dvalid  output  REQUESTERS  read data valid.
REQ-012 r_data  output  REQUESTERS x DATA_WIDTH  read data per requester.
REQ-013 w_addr  input  REQUESTERS x ADDR_WIDTH  write address.
REQ-014 w_data  input  REQUESTERS x DATA_WIDTH  write data.
REQ-015 w_valid  input  REQUESTERS  write request valid.
REQ-016 w_ready  output  REQUESTERS  write accepted this cycle.

Function
REQ-017 Bank select SHALL be addr[log2(BANKS)-1:0]; word index within bank SHALL be the remaining upper bits.
REQ-018 Each bank SHALL serve at most one read and one write per cycle; reads and writes SHALL be arbitrated independently per bank.
REQ-019 r_aready[i] / w_ready[i] SHALL be combinational grants: asserted only when the matching valid is high and requester i wins its target bank's arbiter.
REQ-020 Requesters targeting different banks SHALL all be granted in the same cycle.
REQ-021 A write handshake SHALL update the bank on the next rising edge.
REQ-022 A read handshake in cycle T SHALL assert r_dvalid[i] for exactly one cycle at T+READ_LAT, with r_data[i] holding the word.
REQ-023 Read data SHALL be routed to the originating requester only; other requesters' r_dvalid stay low.
REQ-024 r_data[i] SHALL be zero whenever r_dvalid[i] is low.
REQ-025 Read and write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-026 Back-to-back reads by one requester SHALL be accepted every cycle without bubbles; responses return in order.
REQ-027 Unwritten locations SHALL read as unknown; the bench SHALL not check them.

Reset
REQ-028 In reset: r_dvalid=0, r_data=0, all arbiter pointers=0, in-flight read pipeline cleared; r_aready/w_ready=0 while rst=1.
REQ-029 Reads in flight when rst asserts SHALL never produce r_dvalid; memory contents SHALL be preserved (not reset).

Configuration
REQ-030 With MBM_ROUND_ROBIN_EN defined, each bank arbiter SHALL be round-robin: after granting index g, the pointer moves to (g+1) mod REQUESTERS and the search starts there.
REQ-031 Without MBM_ROUND_ROBIN_EN, each bank arbiter SHALL be fixed priority, lowest requester index wins; no pointer state exists.

Structure
REQ-032 Package mbm_pkg SHALL hold the bank-index width function/constant, the read-pipeline entry typedef (valid, requester index, bank index) and the default parameter values.
REQ-033 One sub-module, mbm_arbiter (parameter N; req, grant, clk, rst), SHALL be instantiated per bank per direction.

Verification
REQ-034 Write 0xA5A5_0001 to addr 4 from req 0, then read addr 4 from req 3 -> r_dvalid[3] exactly READ_LAT cycles after handshake, r_data[3]=0xA5A5_0001, others idle.
REQ-035 Same cycle: req 0 reads addr 2 (bank 0), req 1 reads addr 3 (bank 1) -> both r_aready high, both responses at T+READ_LAT.
REQ-036 Reqs 0..3 continuously read bank 0 -> round-robin grants 0,1,2,3,0,...; without macro req 0 granted every cycle, others starved.
REQ-037 Addr 8 holds 0x11; same cycle write 0x22 and read addr 8 -> read returns 0x11; next read returns 0x22.
REQ-038 Issue 3 back-to-back reads, assert rst one cycle -> no r_dvalid afterwards, pointers back to 0, previously written data still readable.

Source files
------------

// File: rtl/mbm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbm_pkg
// Description : Shared definitions for the multi-bank memory. Holds the
//               default parameter values, index-width helper functions and the
//               read-pipeline entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package mbm_pkg;

    localparam int C_DEF_REQUESTERS = 4;
    localparam int C_DEF_BANKS      = 2;
    localparam int C_DEF_DATA_WIDTH = 32;
    localparam int C_DEF_ADDR_WIDTH = 6;
    localparam int C_DEF_READ_LAT   = 2;

    // Fixed field width for requester/bank indices inside pipeline entries.
    // Supports up to 256 requesters and 256 banks.
    localparam int C_IDX_MAX_W = 8;

    // Number of address bits used for bank select (zero for a single bank).
    function automatic int bank_sel_bits(input int banks);
        return (banks > 1) ? $clog2(banks) : 0;
    endfunction

    // Width of a signal indexing n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [C_IDX_MAX_W-1:0] req;
        logic [C_IDX_MAX_W-1:0] bank;
    } rd_pipe_entry_t;

endpackage
`default_nettype wire

// File: rtl/mbm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mbm_arbiter
// Description : One-hot grant arbiter for a single bank and direction.
//               MBM_ROUND_ROBIN_EN defined : round-robin; after granting g
//                                            the search starts at g+1.
//               MBM_ROUND_ROBIN_EN undefined: fixed priority, lowest index
//                                            wins, no pointer state.
// Ports       : clk   - clock
//               rst   - synchronous active-high reset (clears pointer)
//               req   - N request lines
//               grant - N one-hot combinational grant lines
// Revision    : 1.0 - initial release
// ============================================================================
module mbm_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

`ifdef MBM_ROUND_ROBIN_EN
    localparam int C_PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [C_PTR_W-1:0] r_ptr;
    logic [C_PTR_W-1:0] w_ptr_nxt;

    // Two passes: indices at/after the pointer first, then the wrap-around.
    always_comb begin
        grant     = '0;
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (grant == '0 && req[i] && i >= int'(r_ptr)) begin
                grant[i]  = 1'b1;
                w_ptr_nxt = (i + 1 == N) ? '0 : C_PTR_W'(i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (grant == '0 && req[i] && i < int'(r_ptr)) begin
                grant[i]  = 1'b1;
                w_ptr_nxt = (i + 1 == N) ? '0 : C_PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    // Stateless arbiter: clock and reset are not needed.
    logic w_unused_ok;
    assign w_unused_ok = clk ^ rst;

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == '0 && req[i]) begin
                grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/multi_bank_memory.sv
`default_nettype none
// ============================================================================
// Module      : multi_bank_memory
// Description : Multi-requester, multi-bank word memory. Each bank has one
//               read and one write arbiter; grants are combinational. Read
//               data returns READ_LAT cycles after the handshake, routed only
//               to the originating requester. Reads see pre-write data when a
//               write to the same word is granted in the same cycle.
//               Optional build macro: MBM_ROUND_ROBIN_EN (round-robin bank
//               arbitration instead of fixed lowest-index priority).
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               r_addr/r_avalid/r_aready - read request channel per requester
//               r_dvalid/r_data          - read response per requester
//               w_addr/w_data/w_valid    - write request per requester
//               w_ready                  - write grant per requester
// Revision    : 1.0 - initial release
// ============================================================================
module multi_bank_memory
    import mbm_pkg::*;
#(
    parameter int REQUESTERS = C_DEF_REQUESTERS,
    parameter int BANKS      = C_DEF_BANKS,
    parameter int DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_DEF_ADDR_WIDTH,
    parameter int READ_LAT   = C_DEF_READ_LAT
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] r_addr,
    input  logic [REQUESTERS-1:0]                 r_avalid,
    output logic [REQUESTERS-1:0]                 r_aready,
    output logic [REQUESTERS-1:0]                 r_dvalid,
    output logic [REQUESTERS-1:0][DATA_WIDTH-1:0] r_data,
    input  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] w_addr,
    input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] w_data,
    input  logic [REQUESTERS-1:0]                 w_valid,
    output logic [REQUESTERS-1:0]                 w_ready
);

    localparam int C_SEL_W  = bank_sel_bits(BANKS);
    localparam int C_BANK_W = idx_width(BANKS);
    localparam int C_WORD_W = ADDR_WIDTH - C_SEL_W;
    localparam int C_WORDS  = 1 << C_WORD_W;

    // BANKS is a power of two, so the modulo/shift are plain bit selects.
    function automatic logic [C_BANK_W-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        return C_BANK_W'(a % BANKS);
    endfunction

    function automatic logic [C_WORD_W-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
        return C_WORD_W'(a >> C_SEL_W);
    endfunction

    logic [BANKS-1:0][REQUESTERS-1:0] w_rd_gnt_all;
    logic [BANKS-1:0][REQUESTERS-1:0] w_wr_gnt_all;
    rd_pipe_entry_t [BANKS-1:0]       w_tail_all;
    logic [BANKS-1:0][DATA_WIDTH-1:0] w_tail_data;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [REQUESTERS-1:0]  w_rd_req, w_rd_gnt;
        logic [REQUESTERS-1:0]  w_wr_req, w_wr_gnt;
        logic                   w_rd_en, w_wr_en;
        logic [C_WORD_W-1:0]    w_rd_word, w_wr_word;
        logic [C_IDX_MAX_W-1:0] w_rd_idx;
        logic [DATA_WIDTH-1:0]  w_wr_data;

        logic [DATA_WIDTH-1:0]  r_mem       [C_WORDS];
        rd_pipe_entry_t         r_pipe      [READ_LAT];
        logic [DATA_WIDTH-1:0]  r_pipe_data [READ_LAT];

        // Requests are suppressed during reset so no grant can be issued.
        always_comb begin
            for (int i = 0; i < REQUESTERS; i++) begin
                w_rd_req[i] = !rst && r_avalid[i] && (bank_of(r_addr[i]) == C_BANK_W'(b));
                w_wr_req[i] = !rst && w_valid[i]  && (bank_of(w_addr[i]) == C_BANK_W'(b));
            end
        end

        mbm_arbiter #(.N(REQUESTERS)) u_rd_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (w_rd_req),
            .grant (w_rd_gnt)
        );

        mbm_arbiter #(.N(REQUESTERS)) u_wr_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (w_wr_req),
            .grant (w_wr_gnt)
        );

        assign w_rd_gnt_all[b] = w_rd_gnt;
        assign w_wr_gnt_all[b] = w_wr_gnt;
        assign w_rd_en         = |w_rd_gnt;
        assign w_wr_en         = |w_wr_gnt;

        always_comb begin
            w_rd_word = '0;
            w_rd_idx  = '0;
            w_wr_word = '0;
            w_wr_data = '0;
            for (int i = 0; i < REQUESTERS; i++) begin
                if (w_rd_gnt[i]) begin
                    w_rd_word = word_of(r_addr[i]);
                    w_rd_idx  = C_IDX_MAX_W'(i);
                end
                if (w_wr_gnt[i]) begin
                    w_wr_word = word_of(w_addr[i]);
                    w_wr_data = w_data[i];
                end
            end
        end

        // Storage is never reset; contents survive rst.
        always_ff @(posedge clk) begin
            if (w_wr_en) begin
                r_mem[w_wr_word] <= w_wr_data;
            end
        end

        // The read samples r_mem in the same edge the write lands, so a
        // same-cycle read of the written word returns the old value.
        always_ff @(posedge clk) begin
            r_pipe_data[0] <= r_mem[w_rd_word];
            for (int k = 1; k < READ_LAT; k++) begin
                r_pipe_data[k] <= r_pipe_data[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < READ_LAT; k++) begin
                    r_pipe[k] <= '0;
                end
            end else begin
                r_pipe[0].valid <= w_rd_en;
                r_pipe[0].req   <= w_rd_idx;
                r_pipe[0].bank  <= C_IDX_MAX_W'(b);
                for (int k = 1; k < READ_LAT; k++) begin
                    r_pipe[k] <= r_pipe[k-1];
                end
            end
        end

        assign w_tail_all[b]  = r_pipe[READ_LAT-1];
        assign w_tail_data[b] = r_pipe_data[READ_LAT-1];
    end : g_bank

    always_comb begin
        r_aready = '0;
        w_ready  = '0;
        for (int b = 0; b < BANKS; b++) begin
            r_aready = r_aready | w_rd_gnt_all[b];
            w_ready  = w_ready  | w_wr_gnt_all[b];
        end
    end

    // A requester issues at most one read per cycle, so at most one bank tail
    // can match it. Outputs are forced idle while rst is high.
    always_comb begin
        r_dvalid = '0;
        r_data   = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            for (int b = 0; b < BANKS; b++) begin
                if (!rst && w_tail_all[b].valid &&
                    w_tail_all[b].req  == C_IDX_MAX_W'(i) &&
                    w_tail_all[b].bank == C_IDX_MAX_W'(b)) begin
                    r_dvalid[i] = 1'b1;
                    r_data[i]   = w_tail_data[b];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_bank_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_bank_memory
// Description : Self-checking bench for multi_bank_memory. A per-cycle
//               reference model (address-indexed memory, per-bank arbitration
//               rule, response schedule by due cycle) is compared against the
//               DUT on every negative clock edge; directed vectors add
//               literal expectations. Honours MBM_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_bank_memory;

    localparam int R  = 4;
    localparam int B  = 2;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int RL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [R-1:0][AW-1:0] r_addr, w_addr;
    logic [R-1:0]         r_avalid, r_aready, r_dvalid, w_valid, w_ready;
    logic [R-1:0][DW-1:0] r_data, w_data;

    multi_bank_memory #(
        .REQUESTERS (R),
        .BANKS      (B),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .READ_LAT   (RL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .r_addr   (r_addr),
        .r_avalid (r_avalid),
        .r_aready (r_aready),
        .r_dvalid (r_dvalid),
        .r_data   (r_data),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem   [1<<AW];
    bit            m_known [1<<AW];
    bit            sb_v [8][R];
    logic [DW-1:0] sb_d [8][R];
    bit            sb_k [8][R];
    int            rd_ptr [B];
    int            wr_ptr [B];

    // First requesting index found scanning cyclically from ptr; -1 if none.
    function automatic int winner(input logic [R-1:0] reqs, input int ptr);
        for (int k = 0; k < R; k++) begin
            if (reqs[(ptr + k) % R]) return (ptr + k) % R;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [R-1:0] exp_dv, exp_rg, exp_wg, rq, wq;
        int s, ns, w, a;
        int rw [B];
        int ww [B];
        if (rst) begin
            for (int t = 0; t < 8; t++)
                for (int i = 0; i < R; i++) sb_v[t][i] = 1'b0;
            for (int b = 0; b < B; b++) begin
                rd_ptr[b] = 0;
                wr_ptr[b] = 0;
            end
            chk("rst_dvalid", r_dvalid, '0);
            chk("rst_rdata",  r_data,   '0);
            chk("rst_aready", r_aready, '0);
            chk("rst_wready", w_ready,  '0);
        end else begin
            s = cyc % 8;
            exp_dv = '0;
            for (int i = 0; i < R; i++) exp_dv[i] = sb_v[s][i];
            chk("model_dvalid", r_dvalid, exp_dv);
            for (int i = 0; i < R; i++) begin
                if (!sb_v[s][i]) chk("model_rdata_idle", r_data[i], '0);
                else if (sb_k[s][i]) chk("model_rdata", r_data[i], sb_d[s][i]);
                sb_v[s][i] = 1'b0;
            end
            exp_rg = '0;
            exp_wg = '0;
            for (int b = 0; b < B; b++) begin
                rq = '0;
                wq = '0;
                for (int i = 0; i < R; i++) begin
                    if (r_avalid[i] && (int'(r_addr[i]) % B) == b) rq[i] = 1'b1;
                    if (w_valid[i]  && (int'(w_addr[i]) % B) == b) wq[i] = 1'b1;
                end
                rw[b] = winner(rq, rd_ptr[b]);
                ww[b] = winner(wq, wr_ptr[b]);
                if (rw[b] >= 0) exp_rg[rw[b]] = 1'b1;
                if (ww[b] >= 0) exp_wg[ww[b]] = 1'b1;
`ifdef MBM_ROUND_ROBIN_EN
                if (rw[b] >= 0) rd_ptr[b] = (rw[b] + 1) % R;
                if (ww[b] >= 0) wr_ptr[b] = (ww[b] + 1) % R;
`endif
            end
            chk("model_aready", r_aready, exp_rg);
            chk("model_wready", w_ready,  exp_wg);
            // Reads capture memory before this cycle's writes take effect.
            ns = (cyc + RL) % 8;
            for (int b = 0; b < B; b++) begin
                w = rw[b];
                if (w >= 0) begin
                    a = int'(r_addr[w]);
                    sb_v[ns][w] = 1'b1;
                    sb_d[ns][w] = m_mem[a];
                    sb_k[ns][w] = m_known[a];
                end
            end
            for (int b = 0; b < B; b++) begin
                w = ww[b];
                if (w >= 0) begin
                    a = int'(w_addr[w]);
                    m_mem[a]   = w_data[w];
                    m_known[a] = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r_avalid = '0;
        w_valid  = '0;
        r_addr   = '0;
        w_addr   = '0;
        w_data   = '0;
    endtask

    initial begin
        // Reset with every request asserted: nothing may be granted.
        rst      = 1'b1;
        r_avalid = '1;
        w_valid  = '1;
        r_addr   = '0;
        w_addr   = '1;
        w_data   = '0;
        @(negedge clk);
        chk("reset_aready", r_aready, 4'b0000);
        chk("reset_wready", w_ready,  4'b0000);
        chk("reset_dvalid", r_dvalid, 4'b0000);
        step();
        step();
        rst = 1'b0;
        idle();

        // Write from req 0, read back from req 3.
        w_valid[0] = 1'b1; w_addr[0] = 6'd4; w_data[0] = 32'hA5A5_0001;
        @(negedge clk);
        chk("t1_wready", w_ready, 4'b0001);
        step(); idle();
        r_avalid[3] = 1'b1; r_addr[3] = 6'd4;
        @(negedge clk);
        chk("t1_aready", r_aready, 4'b1000);
        step(); idle();
        for (int k = 1; k < RL; k++) begin
            @(negedge clk);
            chk("t1_not_early", r_dvalid, 4'b0000);
            step();
        end
        @(negedge clk);
        chk("t1_dvalid", r_dvalid, 4'b1000);
        chk("t1_rdata",  r_data[3], 32'hA5A5_0001);
        step();
        @(negedge clk);
        chk("t1_one_cycle", r_dvalid, 4'b0000);

        // Parallel accesses to different banks.
        step(); idle();
        w_valid = 4'b0011;
        w_addr[0] = 6'd2; w_data[0] = 32'h0000_0202;
        w_addr[1] = 6'd3; w_data[1] = 32'h0000_0303;
        @(negedge clk);
        chk("t2_wready", w_ready, 4'b0011);
        step(); idle();
        r_avalid = 4'b0011; r_addr[0] = 6'd2; r_addr[1] = 6'd3;
        @(negedge clk);
        chk("t2_aready", r_aready, 4'b0011);
        step(); idle();
        repeat (RL - 1) step();
        @(negedge clk);
        chk("t2_dvalid", r_dvalid, 4'b0011);
        chk("t2_rdata0", r_data[0], 32'h0000_0202);
        chk("t2_rdata1", r_data[1], 32'h0000_0303);

        // Read-before-write on the same address.
        step(); idle();
        w_valid[0] = 1'b1; w_addr[0] = 6'd8; w_data[0] = 32'h11;
        step(); idle();
        w_valid[1] = 1'b1; w_addr[1] = 6'd8; w_data[1] = 32'h22;
        r_avalid[2] = 1'b1; r_addr[2] = 6'd8;
        @(negedge clk);
        chk("t4_grants", {r_aready, w_ready}, {4'b0100, 4'b0010});
        step(); idle();
        r_avalid[2] = 1'b1; r_addr[2] = 6'd8;
        step(); idle();
        repeat (RL - 2) step();
        @(negedge clk);
        chk("t4_old_data", r_data[2], 32'h11);
        step();
        @(negedge clk);
        chk("t4_new_data", r_data[2], 32'h22);

        // Back-to-back reads, then reset with reads in flight.
        step(); idle();
        r_avalid[0] = 1'b1; r_addr[0] = 6'd4;
        step();
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_dvalid", r_dvalid, 4'b0000);
        chk("t5_rst_aready", r_aready, 4'b0000);
        step();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("t5_flush1", r_dvalid, 4'b0000);
        step();
        @(negedge clk);
        chk("t5_flush2", r_dvalid, 4'b0000);

        // All requesters contend for bank 0 starting from a reset pointer.
        step();
        r_avalid = '1;
        r_addr[0] = 6'd4; r_addr[1] = 6'd2; r_addr[2] = 6'd8; r_addr[3] = 6'd4;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef MBM_ROUND_ROBIN_EN
            chk("t3_rr_grant", r_aready, 4'b0001 << (k % 4));
`else
            chk("t3_fixed_grant", r_aready, 4'b0001);
`endif
            step();
        end
        idle();
        repeat (RL + 1) step();

        // Memory contents survive reset.
        r_avalid[1] = 1'b1; r_addr[1] = 6'd4;
        step(); idle();
        repeat (RL - 1) step();
        @(negedge clk);
        chk("t5_preserved", r_data[1], 32'hA5A5_0001);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
